// File: rtl/rfphoenix_rob_sched_if.sv
// rtl/rfphoenix_rob_sched_if.sv - allocate/issue/done/commit/flush bus of the rfPhoenix ROB scheduler
interface rfphoenix_rob_sched_if #(
    parameter int NENTRIES = 12,
    parameter int NTHREADS = 16,
    parameter int NSTEPS   = 16
);
    localparam int IW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
    localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
    localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    logic                alloc_v_i;
    logic [TW-1:0]       alloc_thread_i;
    logic                alloc_mc_i;
    logic [SW-1:0]       alloc_steps_i;
    logic                alloc_rdy_o;
    logic [IW-1:0]       alloc_idx_o;
    logic [NTHREADS-1:0] thread_rdy_o;
    logic                issue_v_o;
    logic [IW-1:0]       issue_idx_o;
    logic                issue_mc_o;
    logic [SW-1:0]       issue_step_o;
    logic                issue_rdy_i;
    logic                mc_busy_o;
    logic                mc_done_i;
    logic                done_v_i;
    logic [IW-1:0]       done_idx_i;
    logic                commit_v_o;
    logic [IW-1:0]       commit_idx_o;
    logic [TW-1:0]       commit_thread_o;
    logic                commit_ack_i;
    logic                flush_v_i;
    logic [TW-1:0]       flush_thread_i;

    modport slave (
        input  alloc_v_i, alloc_thread_i, alloc_mc_i, alloc_steps_i,
        output alloc_rdy_o, alloc_idx_o, thread_rdy_o,
        output issue_v_o, issue_idx_o, issue_mc_o, issue_step_o,
        input  issue_rdy_i,
        output mc_busy_o,
        input  mc_done_i, done_v_i, done_idx_i,
        output commit_v_o, commit_idx_o, commit_thread_o,
        input  commit_ack_i, flush_v_i, flush_thread_i
    );

    modport master (
        output alloc_v_i, alloc_thread_i, alloc_mc_i, alloc_steps_i,
        input  alloc_rdy_o, alloc_idx_o, thread_rdy_o,
        input  issue_v_o, issue_idx_o, issue_mc_o, issue_step_o,
        output issue_rdy_i,
        input  mc_busy_o,
        output mc_done_i, done_v_i, done_idx_i,
        input  commit_v_o, commit_idx_o, commit_thread_o,
        output commit_ack_i, flush_v_i, flush_thread_i
    );
endinterface

// File: rtl/rfphoenix_rob_sched.sv
// rtl/rfphoenix_rob_sched.sv - per-thread in-order reorder-buffer scheduler for the rfPhoenix core
// ROB_SCHED_RR_EN selects a round-robin issue pick; otherwise lowest index wins.
module rfphoenix_rob_sched #(
    parameter int NENTRIES     = 12,
    parameter int NTHREADS     = 16,
    parameter int THREAD_DEPTH = 2,
    parameter int NSTEPS       = 16
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    rfphoenix_rob_sched_if.slave bus
);
    localparam int IW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
    localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
    localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int QW = $clog2(THREAD_DEPTH) + 1;
    localparam logic [QW-1:0] DEPTH_C = QW'(THREAD_DEPTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_DEC   = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    logic [1:0]    ent_st     [NENTRIES];
    logic [TW-1:0] ent_thread [NENTRIES];
    logic          ent_mc     [NENTRIES];
    logic [SW-1:0] ent_step   [NENTRIES];
    logic [SW-1:0] ent_last   [NENTRIES];
    logic [QW-1:0] ent_seq    [NENTRIES];
    logic [QW-1:0] credit     [NTHREADS];
    logic [QW-1:0] alloc_seq  [NTHREADS];
    logic [QW-1:0] commit_seq [NTHREADS];
    logic          mc_busy;
    logic [IW-1:0] mc_idx;

    logic [NENTRIES-1:0] free_v, iss_cand, cmt_cand;
    logic [NTHREADS-1:0] thread_rdy;
    logic [IW-1:0]       alloc_idx, issue_idx, commit_idx;
    logic                alloc_fire, issue_acc, issue_fire, done_fire, commit_fire;

    function automatic logic [IW-1:0] pick_low(input logic [NENTRIES-1:0] v);
        pick_low = '0;
        for (int i = NENTRIES - 1; i >= 0; i--)
            if (v[i]) pick_low = IW'(i);
    endfunction

`ifdef ROB_SCHED_RR_EN
    logic [IW-1:0]       rr_ptr;
    logic [NENTRIES-1:0] iss_hi;
`endif

    always_comb begin
        for (int i = 0; i < NENTRIES; i++) begin
            // The entry that launched the running mc op stays reserved so a late done cannot hit a new owner.
            free_v[i]   = (ent_st[i] == ST_EMPTY) && !(mc_busy && mc_idx == IW'(i));
            iss_cand[i] = (ent_st[i] == ST_DEC) && !(ent_mc[i] && mc_busy);
            cmt_cand[i] = (ent_st[i] == ST_EXEC) && (ent_seq[i] == commit_seq[ent_thread[i]]);
        end
        for (int t = 0; t < NTHREADS; t++)
            thread_rdy[t] = credit[t] < DEPTH_C;
        alloc_idx  = pick_low(free_v);
        commit_idx = pick_low(cmt_cand);
`ifdef ROB_SCHED_RR_EN
        for (int i = 0; i < NENTRIES; i++)
            iss_hi[i] = iss_cand[i] && (IW'(i) >= rr_ptr);
        issue_idx = (|iss_hi) ? pick_low(iss_hi) : pick_low(iss_cand);
`else
        issue_idx = pick_low(iss_cand);
`endif
    end

    assign bus.alloc_rdy_o     = |free_v;
    assign bus.alloc_idx_o     = alloc_idx;
    assign bus.thread_rdy_o    = thread_rdy;
    assign bus.issue_v_o       = |iss_cand;
    assign bus.issue_idx_o     = issue_idx;
    assign bus.issue_mc_o      = ent_mc[issue_idx];
    assign bus.issue_step_o    = ent_step[issue_idx];
    assign bus.mc_busy_o       = mc_busy;
    assign bus.commit_v_o      = |cmt_cand;
    assign bus.commit_idx_o    = commit_idx;
    assign bus.commit_thread_o = ent_thread[commit_idx];

    // A flush of the owning thread overrides every same-cycle event on its entries.
    assign alloc_fire  = bus.alloc_v_i && (|free_v) && thread_rdy[bus.alloc_thread_i]
                         && !(bus.flush_v_i && bus.flush_thread_i == bus.alloc_thread_i);
    assign issue_acc   = (|iss_cand) && bus.issue_rdy_i;
    assign issue_fire  = issue_acc && !(bus.flush_v_i && bus.flush_thread_i == ent_thread[issue_idx]);
    assign done_fire   = bus.done_v_i && (ent_st[bus.done_idx_i] == ST_OUT)
                         && !(bus.flush_v_i && bus.flush_thread_i == ent_thread[bus.done_idx_i]);
    assign commit_fire = (|cmt_cand) && bus.commit_ack_i
                         && !(bus.flush_v_i && bus.flush_thread_i == ent_thread[commit_idx]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NENTRIES; i++) begin
                ent_st[i]     <= ST_EMPTY;
                ent_thread[i] <= '0;
                ent_mc[i]     <= 1'b0;
                ent_step[i]   <= '0;
                ent_last[i]   <= '0;
                ent_seq[i]    <= '0;
            end
            for (int t = 0; t < NTHREADS; t++) begin
                credit[t]     <= '0;
                alloc_seq[t]  <= '0;
                commit_seq[t] <= '0;
            end
            mc_busy <= 1'b0;
            mc_idx  <= '0;
        end else begin
            for (int i = 0; i < NENTRIES; i++) begin
                if (bus.flush_v_i && ent_st[i] != ST_EMPTY && ent_thread[i] == bus.flush_thread_i) begin
                    ent_st[i] <= ST_EMPTY;
                end else if (alloc_fire && alloc_idx == IW'(i)) begin
                    ent_st[i]     <= ST_DEC;
                    ent_thread[i] <= bus.alloc_thread_i;
                    ent_mc[i]     <= bus.alloc_mc_i;
                    ent_step[i]   <= '0;
                    ent_last[i]   <= bus.alloc_steps_i;
                    ent_seq[i]    <= alloc_seq[bus.alloc_thread_i];
                end else if (issue_fire && issue_idx == IW'(i)) begin
                    ent_st[i] <= ST_OUT;
                end else if (done_fire && bus.done_idx_i == IW'(i)) begin
                    if (ent_step[i] < ent_last[i]) begin
                        ent_step[i] <= ent_step[i] + 1'b1;
                        ent_st[i]   <= ST_DEC;
                    end else begin
                        ent_st[i] <= ST_EXEC;
                    end
                end else if (commit_fire && commit_idx == IW'(i)) begin
                    ent_st[i] <= ST_EMPTY;
                end
            end
            for (int t = 0; t < NTHREADS; t++) begin
                if (bus.flush_v_i && bus.flush_thread_i == TW'(t)) begin
                    credit[t]     <= '0;
                    alloc_seq[t]  <= '0;
                    commit_seq[t] <= '0;
                end else begin
                    if (alloc_fire && bus.alloc_thread_i == TW'(t))
                        alloc_seq[t] <= alloc_seq[t] + 1'b1;
                    if (commit_fire && ent_thread[commit_idx] == TW'(t))
                        commit_seq[t] <= commit_seq[t] + 1'b1;
                    if ((alloc_fire && bus.alloc_thread_i == TW'(t))
                        && !(commit_fire && ent_thread[commit_idx] == TW'(t)))
                        credit[t] <= credit[t] + 1'b1;
                    else if (!(alloc_fire && bus.alloc_thread_i == TW'(t))
                             && (commit_fire && ent_thread[commit_idx] == TW'(t)))
                        credit[t] <= credit[t] - 1'b1;
                end
            end
            // The mc unit is physically occupied once it accepts, even if the op is flushed that cycle.
            if (issue_acc && ent_mc[issue_idx]) begin
                mc_busy <= 1'b1;
                mc_idx  <= issue_idx;
            end else if (bus.mc_done_i) begin
                mc_busy <= 1'b0;
            end
        end
    end

`ifdef ROB_SCHED_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            rr_ptr <= '0;
        else if (issue_acc)
            rr_ptr <= (issue_idx == IW'(NENTRIES - 1)) ? '0 : issue_idx + 1'b1;
    end
`endif
endmodule

// File: tb/tb_rfphoenix_rob_sched.sv
// tb/tb_rfphoenix_rob_sched.sv - directed self-checking bench for rfphoenix_rob_sched
module tb_rfphoenix_rob_sched;
    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk_i = ~clk_i;

    rfphoenix_rob_sched_if #(.NENTRIES(12), .NTHREADS(16), .NSTEPS(16)) bus ();

    rfphoenix_rob_sched #(.NENTRIES(12), .NTHREADS(16), .THREAD_DEPTH(2), .NSTEPS(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        bus.alloc_v_i      = 1'b0;
        bus.alloc_thread_i = 4'd0;
        bus.alloc_mc_i     = 1'b0;
        bus.alloc_steps_i  = 4'd0;
        bus.issue_rdy_i    = 1'b0;
        bus.mc_done_i      = 1'b0;
        bus.done_v_i       = 1'b0;
        bus.done_idx_i     = 4'd0;
        bus.commit_ack_i   = 1'b0;
        bus.flush_v_i      = 1'b0;
        bus.flush_thread_i = 4'd0;
    endtask

    task automatic do_reset();
        clr();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        int t6_thr[5];
        int rr_exp[3];
        t6_thr = '{2, 9, 10, 11, 2};
`ifdef ROB_SCHED_RR_EN
        rr_exp = '{4, 5, 0};
`else
        rr_exp = '{0, 4, 5};
`endif
        clr();
        rst_ni = 1'b0;
        tick();
        tick();
        check("rst_alloc_rdy", 32'(bus.alloc_rdy_o), 32'd1);
        check("rst_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);
        check("rst_thread_rdy", 32'(bus.thread_rdy_o), 32'hFFFF);
        check("rst_issue_v", 32'(bus.issue_v_o), 32'd0);
        check("rst_commit_v", 32'(bus.commit_v_o), 32'd0);
        check("rst_mc_busy", 32'(bus.mc_busy_o), 32'd0);
        rst_ni = 1'b1;

        // single scalar op, thread 3
        bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'd3;
        check("t1_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);
        tick();
        bus.alloc_v_i = 1'b0;
        check("t1_issue_v", 32'(bus.issue_v_o), 32'd1);
        check("t1_issue_idx", 32'(bus.issue_idx_o), 32'd0);
        check("t1_alloc_idx_next", 32'(bus.alloc_idx_o), 32'd1);
        bus.issue_rdy_i = 1'b1;
        tick();
        bus.issue_rdy_i = 1'b0;
        check("t1_issue_v_after", 32'(bus.issue_v_o), 32'd0);
        bus.done_v_i = 1'b1; bus.done_idx_i = 4'd0;
        tick();
        bus.done_v_i = 1'b0;
        check("t1_commit_v", 32'(bus.commit_v_o), 32'd1);
        check("t1_commit_idx", 32'(bus.commit_idx_o), 32'd0);
        check("t1_commit_thread", 32'(bus.commit_thread_o), 32'd3);
        bus.commit_ack_i = 1'b1;
        tick();
        bus.commit_ack_i = 1'b0;
        check("t1_commit_v_after", 32'(bus.commit_v_o), 32'd0);
        check("t1_alloc_idx_free", 32'(bus.alloc_idx_o), 32'd0);
        check("t1_thread_rdy", 32'(bus.thread_rdy_o), 32'hFFFF);

        // credit limit and in-order commit, thread 5
        do_reset();
        bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'd5;
        tick(); tick(); tick();
        bus.alloc_v_i = 1'b0;
        check("t2_thread_rdy5", 32'(bus.thread_rdy_o[5]), 32'd0);
        check("t2_alloc_idx", 32'(bus.alloc_idx_o), 32'd2);
        bus.issue_rdy_i = 1'b1;
        tick(); tick();
        bus.issue_rdy_i = 1'b0;
        check("t2_issue_v", 32'(bus.issue_v_o), 32'd0);
        bus.done_v_i = 1'b1; bus.done_idx_i = 4'd1;
        tick();
        check("t2_commit_blocked", 32'(bus.commit_v_o), 32'd0);
        bus.done_idx_i = 4'd0;
        tick();
        bus.done_v_i = 1'b0;
        check("t2_commit_v0", 32'(bus.commit_v_o), 32'd1);
        check("t2_commit_idx0", 32'(bus.commit_idx_o), 32'd0);
        bus.commit_ack_i = 1'b1;
        tick();
        check("t2_commit_v1", 32'(bus.commit_v_o), 32'd1);
        check("t2_commit_idx1", 32'(bus.commit_idx_o), 32'd1);
        tick();
        bus.commit_ack_i = 1'b0;
        check("t2_commit_done", 32'(bus.commit_v_o), 32'd0);
        check("t2_thread_rdy5_back", 32'(bus.thread_rdy_o[5]), 32'd1);

        // multicycle unit serialisation
        do_reset();
        bus.alloc_v_i = 1'b1; bus.alloc_mc_i = 1'b1; bus.alloc_thread_i = 4'd7;
        tick();
        bus.alloc_thread_i = 4'd8;
        tick();
        bus.alloc_v_i = 1'b0; bus.alloc_mc_i = 1'b0;
        check("t3_issue_idx0", 32'(bus.issue_idx_o), 32'd0);
        check("t3_issue_mc", 32'(bus.issue_mc_o), 32'd1);
        bus.issue_rdy_i = 1'b1;
        tick();
        bus.issue_rdy_i = 1'b0;
        check("t3_mc_busy", 32'(bus.mc_busy_o), 32'd1);
        check("t3_withheld", 32'(bus.issue_v_o), 32'd0);
        bus.mc_done_i = 1'b1;
        tick();
        bus.mc_done_i = 1'b0;
        check("t3_mc_idle", 32'(bus.mc_busy_o), 32'd0);
        check("t3_issue_v", 32'(bus.issue_v_o), 32'd1);
        check("t3_issue_idx1", 32'(bus.issue_idx_o), 32'd1);

        // 16-step gather
        do_reset();
        bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'd1; bus.alloc_steps_i = 4'd15;
        tick();
        bus.alloc_v_i = 1'b0; bus.alloc_steps_i = 4'd0;
        for (int k = 0; k < 16; k++) begin
            check("t4_issue_v", 32'(bus.issue_v_o), 32'd1);
            check("t4_issue_step", 32'(bus.issue_step_o), 32'(k));
            bus.issue_rdy_i = 1'b1;
            tick();
            bus.issue_rdy_i = 1'b0;
            bus.done_v_i = 1'b1; bus.done_idx_i = 4'd0;
            tick();
            bus.done_v_i = 1'b0;
            if (k < 15) check("t4_not_exec", 32'(bus.commit_v_o), 32'd0);
        end
        check("t4_exec", 32'(bus.commit_v_o), 32'd1);

        // full ROB, free slot reusable only the next cycle
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'(i / 2);
            check("t5_fill_idx", 32'(bus.alloc_idx_o), 32'(i));
            tick();
        end
        bus.alloc_v_i = 1'b0;
        check("t5_full", 32'(bus.alloc_rdy_o), 32'd0);
        bus.issue_rdy_i = 1'b1;
        tick();
        bus.issue_rdy_i = 1'b0;
        bus.done_v_i = 1'b1; bus.done_idx_i = 4'd0;
        tick();
        bus.done_v_i = 1'b0;
        check("t5_commit_idx", 32'(bus.commit_idx_o), 32'd0);
        bus.commit_ack_i = 1'b1; bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'd8;
        tick();
        bus.commit_ack_i = 1'b0;
        check("t5_freed_rdy", 32'(bus.alloc_rdy_o), 32'd1);
        check("t5_freed_idx", 32'(bus.alloc_idx_o), 32'd0);
        tick();
        bus.alloc_v_i = 1'b0;
        check("t5_refull", 32'(bus.alloc_rdy_o), 32'd0);
        check("t5_new_issue_idx", 32'(bus.issue_idx_o), 32'd0);

        // flush thread 2 with a same-cycle commit of thread 9
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'(t6_thr[i]);
            tick();
        end
        bus.alloc_v_i = 1'b0;
        bus.issue_rdy_i = 1'b1;
        repeat (5) tick();
        bus.issue_rdy_i = 1'b0;
        bus.done_v_i = 1'b1; bus.done_idx_i = 4'd4;
        tick();
        bus.done_idx_i = 4'd1;
        tick();
        bus.done_v_i = 1'b0;
        check("t6_commit_idx", 32'(bus.commit_idx_o), 32'd1);
        check("t6_commit_thread", 32'(bus.commit_thread_o), 32'd9);
        bus.flush_v_i = 1'b1; bus.flush_thread_i = 4'd2; bus.commit_ack_i = 1'b1;
        tick();
        clr();
        check("t6_commit_v", 32'(bus.commit_v_o), 32'd0);
        check("t6_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);
        check("t6_thread_rdy2", 32'(bus.thread_rdy_o[2]), 32'd1);
        bus.done_v_i = 1'b1; bus.done_idx_i = 4'd0;
        tick();
        bus.done_v_i = 1'b0;
        check("t6_late_done_idx", 32'(bus.alloc_idx_o), 32'd0);
        check("t6_late_done_cv", 32'(bus.commit_v_o), 32'd0);
        bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'd2;
        tick(); tick();
        bus.alloc_v_i = 1'b0;
        check("t6_credit_full", 32'(bus.thread_rdy_o[2]), 32'd0);
        check("t6_alloc_idx_after", 32'(bus.alloc_idx_o), 32'd4);

        // issue pick order
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.alloc_v_i = 1'b1; bus.alloc_thread_i = 4'(i); bus.alloc_steps_i = 4'd1;
            tick();
        end
        clr();
        bus.issue_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t7_issue_order", 32'(bus.issue_idx_o), 32'(i));
            tick();
        end
        bus.issue_rdy_i = 1'b0;
        bus.done_v_i = 1'b1; bus.done_idx_i = 4'd0;
        tick();
        bus.done_v_i = 1'b0;
        bus.issue_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t7_issue_pick", 32'(bus.issue_idx_o), 32'(rr_exp[i]));
            tick();
        end
        bus.issue_rdy_i = 1'b0;
        check("t7_drained", 32'(bus.issue_v_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
